// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with several read ports and a serial debug dump.
//
// Provides NUM_RD combinational read ports, one synchronous write port and a
// hardwired-zero register 0. A two-state debug sequencer streams every
// register out through dbg_idx/dbg_data, one register per cycle.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward WData combinationally
// to any read port whose address matches a write on the same cycle. The dump
// path is never bypassed.

module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WR,
  input  logic [DATA_W-1:0]        WData,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     dbg_start,
  output logic                     dbg_busy,
  output logic                     dbg_valid,
  output logic [ADDR_W-1:0]        dbg_idx,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     dbg_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  // Writes to register 0 are discarded so it always reads back as zero.
  assign wr_en = RegWrite && (WR != '0);

  // Register storage: cleared on reset, one write per rising edge.
  // NOTE: the array is reset because the register file must come up all-zero;
  // a storage array without that requirement would be left unreset so it can
  // map onto RAM or cheaper non-reset flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking assignment keeps the pre-edge value visible to every
      // other process sampling regs on this edge (the dump relies on it).
      regs[WR] <= WData;
    end
  end

  // Combinational read ports with optional same-cycle write-through.
  always_comb begin
    // NOTE: assigning a default before the loop guarantees every bit is driven
    // on every path, so no latch can be inferred.
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (raddr[k*ADDR_W +: ADDR_W] != '0) begin
        rdata[k*DATA_W +: DATA_W] = regs[raddr[k*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (raddr[k*ADDR_W +: ADDR_W] == WR)) begin
          rdata[k*DATA_W +: DATA_W] = WData;
        end
`else
`endif
      end
    end
  end

  // Dump sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dump sequencer next-state logic; a start request during DUMP is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dbg_start) state_nxt = DUMP;
      DUMP:    if (cnt == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dump sequencer Moore output: busy for as long as entries are being emitted.
  always_comb begin
    dbg_busy = (state == DUMP);
  end

  // Dump index counter; it only returns to 0 by leaving DUMP, never by wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == DUMP) && (cnt != LAST_IDX)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Registered dump stream: one entry per DUMP cycle, then a single done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_valid <= 1'b0;
      dbg_idx   <= '0;
      dbg_data  <= '0;
      dbg_done  <= 1'b0;
    end else if (state == DUMP) begin
      dbg_valid <= 1'b1;
      dbg_idx   <= cnt;
      dbg_data  <= regs[cnt];
      dbg_done  <= 1'b0;
    end else begin
      // In IDLE dbg_valid can only still be high on the cycle right after the
      // last entry, which is exactly when the done pulse is due.
      dbg_valid <= 1'b0;
      dbg_done  <= dbg_valid;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed bench for reg_file_mp with a behavioural model.
// The model tracks register contents in a plain array and the dump as
// "which index is next"; a negedge compare process checks the DUT against it
// every cycle, and the directed sequence pins the model with literal values.

module tb_reg_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     RegWrite;
  logic [ADDR_W-1:0]        WR;
  logic [DATA_W-1:0]        WData;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     dbg_start;
  logic                     dbg_busy;
  logic                     dbg_valid;
  logic [ADDR_W-1:0]        dbg_idx;
  logic [DATA_W-1:0]        dbg_data;
  logic                     dbg_done;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .WR        (WR),
    .WData     (WData),
    .raddr     (raddr),
    .rdata     (rdata),
    .dbg_start (dbg_start),
    .dbg_busy  (dbg_busy),
    .dbg_valid (dbg_valid),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data),
    .dbg_done  (dbg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_regs [DEPTH] = '{default: '0};
  bit                m_in_dump   = 1'b0;
  int                m_pos       = 0;
  bit                m_done_pend = 1'b0;
  bit                m_valid     = 1'b0;
  bit                m_done      = 1'b0;
  int                m_idx       = 0;
  logic [DATA_W-1:0] m_data      = '0;

  always @(negedge rst_n) begin
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_in_dump   = 1'b0;
    m_pos       = 0;
    m_done_pend = 1'b0;
    m_valid     = 1'b0;
    m_done      = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (m_in_dump) begin
        m_valid = 1'b1;
        m_idx   = m_pos;
        m_data  = m_regs[m_pos];
        if (m_pos == DEPTH - 1) begin
          m_in_dump   = 1'b0;
          m_done_pend = 1'b1;
        end else begin
          m_pos++;
        end
      end else begin
        m_done      = m_done_pend;
        m_done_pend = 1'b0;
        if (dbg_start) begin
          m_in_dump = 1'b1;
          m_pos     = 0;
        end
      end
      if (RegWrite && WR != 0) m_regs[WR] = WData;
    end
  end

  function automatic logic [DATA_W-1:0] exp_read(input int k);
    logic [ADDR_W-1:0] a;
    a = raddr[k*ADDR_W +: ADDR_W];
    if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (RegWrite && WR != 0 && a == WR) return WData;
`endif
    return m_regs[a];
  endfunction

  // ---------------- per-cycle compare + dump capture ----------------
  int                cap_idx [$];
  logic [DATA_W-1:0] cap_data [$];
  int                done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_busy", 64'(dbg_busy), 64'd0);
      check("rst_valid", 64'(dbg_valid), 64'd0);
      check("rst_done", 64'(dbg_done), 64'd0);
      check("rst_idx", 64'(dbg_idx), 64'd0);
      check("rst_data", 64'(dbg_data), 64'd0);
    end else begin
      for (int k = 0; k < NUM_RD; k++)
        check($sformatf("rdata%0d", k), 64'(rdata[k*DATA_W +: DATA_W]), 64'(exp_read(k)));
      check("busy", 64'(dbg_busy), 64'(m_in_dump));
      check("valid", 64'(dbg_valid), 64'(m_valid));
      check("done", 64'(dbg_done), 64'(m_done));
      if (m_valid) begin
        check("dbg_idx", 64'(dbg_idx), 64'(m_idx));
        check("dbg_data", 64'(dbg_data), 64'(m_data));
      end
      if (dbg_valid) begin
        cap_idx.push_back(int'(dbg_idx));
        cap_data.push_back(dbg_data);
      end
      if (dbg_done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    raddr[0 +: ADDR_W]      = a0;
    raddr[ADDR_W +: ADDR_W] = a1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    RegWrite  = 1'b0;
    WR        = '0;
    WData     = '0;
    raddr     = '0;
    dbg_start = 1'b0;
    repeat (2) tick();
    check("reset_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic write then read on the next cycle.
    set_rd(5, 0);
    WR = 5; WData = 32'h5; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    #1;
    check("wr5_p0", 64'(rdata[0 +: DATA_W]), 64'h5);
    check("wr5_p1", 64'(rdata[DATA_W +: DATA_W]), 64'h0);

    // Writes to register 0 are dropped; it reads 0 before and after the edge.
    set_rd(0, 0);
    WR = 0; WData = 32'hFFFF_FFFF; RegWrite = 1'b1;
    #1;
    check("r0_pre", 64'(rdata), 64'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("r0_post", 64'(rdata), 64'h0);

    // Same-cycle read of the register being written.
    set_rd(3, 4);
    WR = 3; WData = 32'hDEAD_BEEF; RegWrite = 1'b1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("bypass_p0", 64'(rdata[0 +: DATA_W]), 64'hDEAD_BEEF);
`else
    check("nobypass_p0", 64'(rdata[0 +: DATA_W]), 64'h0);
`endif
    check("bypass_p1", 64'(rdata[DATA_W +: DATA_W]), 64'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("wr3_post", 64'(rdata[0 +: DATA_W]), 64'hDEAD_BEEF);

    // Load regs[i] = 3*i, then dump; a second start mid-dump must be ignored,
    // and a write to reg 10 on its own emit edge must not alter the dumped value.
    for (int i = 1; i < DEPTH; i++) begin
      WR = ADDR_W'(i); WData = DATA_W'(3 * i); RegWrite = 1'b1;
      tick();
    end
    RegWrite = 1'b0;
    cap_idx.delete();
    cap_data.delete();
    done_cnt = 0;
    dbg_start = 1'b1;
    tick();                     // E0: start sampled
    dbg_start = 1'b0;
    #1;
    check("busy_after_start", 64'(dbg_busy), 64'd1);
    repeat (3) tick();          // after E3
    dbg_start = 1'b1;
    tick();                     // E4: ignored start
    dbg_start = 1'b0;
    repeat (6) tick();          // after E10
    WR = 10; WData = 32'hA5A5; RegWrite = 1'b1;
    tick();                     // E11 emits index 10
    RegWrite = 1'b0;
    #1;
    check("collide_idx", 64'(dbg_idx), 64'd10);
    check("collide_data", 64'(dbg_data), 64'd30);
    wait_done(40);
    repeat (5) tick();
    check("dump_len", 64'(cap_idx.size()), 64'd32);
    check("done_once", 64'(done_cnt), 64'd1);
    if (cap_idx.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        check($sformatf("dump_idx%0d", i), 64'(cap_idx[i]), 64'(i));
        check($sformatf("dump_data%0d", i), 64'(cap_data[i]), 64'(3 * i));
      end
    end
    check("dump_last", 64'(cap_data[$]), 64'd93);
    set_rd(10, 0);
    #1;
    check("reg10_after", 64'(rdata[0 +: DATA_W]), 64'hA5A5);

    // Reset while index 12 is on the dump outputs aborts everything.
    cap_idx.delete();
    cap_data.delete();
    done_cnt = 0;
    dbg_start = 1'b1;
    tick();                     // E0
    dbg_start = 1'b0;
    repeat (13) tick();         // after E13: index 12 presented
    #1;
    check("abort_idx", 64'(dbg_idx), 64'd12);
    check("abort_data", 64'(dbg_data), 64'd36);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(dbg_valid), 64'd0);
    check("abort_busy", 64'(dbg_busy), 64'd0);
    check("abort_idx0", 64'(dbg_idx), 64'd0);
    check("abort_data0", 64'(dbg_data), 64'd0);
    check("abort_rdata", 64'(rdata[0 +: DATA_W]), 64'd0);
    // Indices 0..11 were sampled on the falling edges before the reset.
    check("abort_caplen", 64'(cap_idx.size()), 64'd12);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // A fresh dump after reset streams all zeros.
    cap_idx.delete();
    cap_data.delete();
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    wait_done(40);
    check("zero_dump_len", 64'(cap_data.size()), 64'd32);
    for (int i = 0; i < cap_data.size(); i++)
      check($sformatf("zero_dump%0d", i), 64'(cap_data[i]), 64'd0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
